uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of byte-stream requesters (2..8).
REQ-002 Parameter: TIMEOUT, default 4096, maximum idle cycles inside a packet before the grant is revoked.
REQ-003 Port: aclk  input  1  system clock (50 MHz); all logic runs on its rising edge.
REQ-004 Port: aresetn  input  1  reset; asynchronous assert, active-low.
REQ-005 Port: req_data  input  NUM_REQ*8  byte from requester i, in bits [8i+7:8i].
REQ-006 Port: req_valid  input  NUM_REQ  byte valid, one bit per requester.
REQ-007 Port: req_last  input  NUM_REQ  marks the final byte of a packet, one bit per requester.
REQ-008 Port: req_ready  output  NUM_REQ  byte accepted from requester i when req_valid[i] and req_ready[i] are both 1.
REQ-009 Port: tx_fifo_data  output  8  byte to the shared UART TX FIFO.
REQ-010 Port: tx_fifo_valid  output  1  tx_fifo_data is valid.
REQ-011 Port: tx_fifo_ready  input  1  TX FIFO accepts the byte.
REQ-012 Port: grant_id  output  $clog2(NUM_REQ)  index of the current or most recent grantee.
REQ-013 Port: busy  output  1  high while in ARB_XFER.
REQ-014 Port: err_timeout  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 The arbiter SHALL use two states: ARB_IDLE and ARB_XFER; any illegal encoding SHALL go to ARB_IDLE.
REQ-016 ARB_IDLE: if any req_valid bit is 1, the arbiter SHALL select the first requester with valid set, searching round-robin from (last_grant+1) mod NUM_REQ.
REQ-017 On that selection the arbiter SHALL register grant_id, clear the idle counter and enter ARB_XFER on the next edge. This gives 1 cycle of arbitration latency.
REQ-018 In ARB_IDLE, req_ready SHALL be all zeros.
REQ-019 ARB_XFER: req_ready[grant_id] SHALL equal (!tx_fifo_valid || tx_fifo_ready), combinationally. All other req_ready bits SHALL be 0.
REQ-020 On each accepted byte, tx_fifo_data SHALL load req_data of the grantee and tx_fifo_valid SHALL be 1 on the next cycle. Input-to-output latency is 1 cycle.
REQ-021 When tx_fifo_valid && tx_fifo_ready and no new byte is accepted in the same cycle, tx_fifo_valid SHALL clear. A simultaneous accept and drain SHALL keep valid at 1 with the new data.
REQ-022 tx_fifo_data and tx_fifo_valid SHALL hold stable while tx_fifo_valid && !tx_fifo_ready.
REQ-023 When the accepted byte has req_last[grant_id]=1, the arbiter SHALL store last_grant<=grant_id and return to ARB_IDLE. Packets from different requesters SHALL never interleave.
REQ-024 The idle counter SHALL increment each ARB_XFER cycle in which req_valid[grant_id]=0, and SHALL clear on any accepted byte.
REQ-025 A stalled tx_fifo_ready SHALL NOT advance the idle counter.
REQ-026 When the idle counter reaches TIMEOUT-1, the arbiter SHALL return to ARB_IDLE, set last_grant<=grant_id and pulse err_timeout for exactly 1 cycle. Any byte already in the output register SHALL still be delivered.
REQ-027 A single-byte packet (valid and last in the first ARB_XFER cycle) SHALL be accepted and SHALL return to ARB_IDLE on the next edge.
REQ-028 busy SHALL be 1 exactly while the state is ARB_XFER.

Reset
REQ-029 When aresetn=0, the block SHALL set state=ARB_IDLE, last_grant=NUM_REQ-1 (so requester 0 wins first), grant_id=0, idle counter=0, tx_fifo_data=8'h00, tx_fifo_valid=0 and err_timeout=0.
REQ-030 Reset asserted mid-packet SHALL drop the packet and any pending output byte immediately. After release, req_ready SHALL stay all zeros until a new arbitration completes.

Verification
REQ-031 Single requester: req 2 sends 3 bytes 0x11,0x22,0x33 with last on 0x33, tx_fifo_ready=1 -> tx_fifo_data shows 0x11,0x22,0x33 on consecutive cycles, grant_id=2, and busy drops after the last accept.
REQ-032 Contention: reqs 0,1,3 each hold a valid 2-byte packet at reset release -> packets are served in order 0,1,3, with no interleaving, then order 0 again on a second round.
REQ-033 Backpressure: tx_fifo_ready=0 for 10 cycles mid-packet -> req_ready[g]=0 and tx_fifo_data is held stable; the stream resumes without byte loss or duplication, and no timeout fires.
REQ-034 Timeout (TIMEOUT=16): grantee 1 sends 1 non-last byte, then valid=0 -> err_timeout pulses exactly once, 16 cycles after that accept, and requester 2 (valid) is granted next.
REQ-035 Simultaneous drain and accept: a held byte with tx_fifo_ready=1 and a new byte valid in the same cycle -> tx_fifo_valid stays 1 and the new byte appears the next cycle.
REQ-036 Reset mid-packet: aresetn pulsed low during byte 2 of 4 -> outputs match REQ-029 immediately, and a fresh arbitration grants requester 0 first.

Source files
------------

// File: rtl/uart_tx_arb_if.sv
// Byte-stream bundle between the requesters, the arbiter and the shared UART TX FIFO.
// The arbiter sits on the slave side; the requesters and the FIFO together form the master side.
interface uart_tx_arb_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_fifo_data;
  logic                 tx_fifo_valid;
  logic                 tx_fifo_ready;

  modport master (
    output req_data, req_valid, req_last, tx_fifo_ready,
    input  req_ready, tx_fifo_data, tx_fifo_valid
  );

  modport slave (
    input  req_data, req_valid, req_last, tx_fifo_ready,
    output req_ready, tx_fifo_data, tx_fifo_valid
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin packet arbiter that feeds several byte streams into one UART TX FIFO.
// A granted requester keeps the FIFO until its last byte or an idle timeout.
module uart_tx_arb #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4096,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic          aclk,
  input  logic          aresetn,
  uart_tx_arb_if.slave  bus,
  output logic [GW-1:0] grant_id,
  output logic          busy,
  output logic          err_timeout
);

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_XFER = 2'b01
  } state_e;

  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  state_e               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_q, last_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;

  logic [GW-1:0]        sel;
  logic                 sel_found;
  int                   rr_idx;
  logic [GW-1:0]        rr_sel;
  logic                 ready_g;
  logic                 g_valid;
  logic                 g_last;
  logic [7:0]           g_data;
  logic                 accept;
  logic                 stall;
  logic [NUM_REQ-1:0]   ready_vec;

  // First valid requester, searching upward from the one after the previous grantee.
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    rr_idx    = 0;
    rr_sel    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_idx = int'(last_q) + k;
      if (rr_idx >= NUM_REQ) begin
        rr_idx = rr_idx - NUM_REQ;
      end
      rr_sel = GW'(rr_idx);
      if (!sel_found && bus.req_valid[rr_sel]) begin
        sel       = rr_sel;
        sel_found = 1'b1;
      end
    end
  end

  always_comb begin
    g_valid   = bus.req_valid[grant_q];
    g_last    = bus.req_last[grant_q];
    g_data    = bus.req_data[grant_q*8 +: 8];
    ready_g   = !valid_q || bus.tx_fifo_ready;
    accept    = (state_q == ARB_XFER) && g_valid && ready_g;
    stall     = valid_q && !bus.tx_fifo_ready;
    ready_vec = '0;
    if (state_q == ARB_XFER) begin
      ready_vec[grant_q] = ready_g;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = 1'b0;

    if (valid_q && bus.tx_fifo_ready) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      data_d  = g_data;
      valid_d = 1'b1;
    end

    case (state_q)
      ARB_IDLE: begin
        if (sel_found) begin
          grant_d = sel;
          cnt_d   = '0;
          state_d = ARB_XFER;
        end
      end
      ARB_XFER: begin
        if (accept) begin
          cnt_d = '0;
          if (g_last) begin
            state_d = ARB_IDLE;
            last_d  = grant_q;
          end
        // Only a silent requester ages the grant; a FIFO stall freezes the count.
        end else if (!g_valid && !stall) begin
          if (cnt_q == CNT_MAX) begin
            state_d = ARB_IDLE;
            last_d  = grant_q;
            err_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      cnt_q   <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready     = ready_vec;
  assign bus.tx_fifo_data  = data_q;
  assign bus.tx_fifo_valid = valid_q;
  assign grant_id          = grant_q;
  assign busy              = (state_q == ARB_XFER);
  assign err_timeout       = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: queued requester packets, a packet-level
// round-robin model of the expected output stream, and directed corner scenarios.
module tb_uart_tx_arb;
  localparam int NUM = 4;
  localparam int TMO = 16;

  logic       aclk    = 1'b0;
  logic       aresetn = 1'b0;
  logic [1:0] grant_id;
  logic       busy;
  logic       err_timeout;

  uart_tx_arb_if #(.NUM_REQ(NUM)) bus();

  uart_tx_arb #(.NUM_REQ(NUM), .TIMEOUT(TMO)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .bus         (bus),
    .grant_id    (grant_id),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #10 aclk = ~aclk;

  int         compared   = 0;
  int         mismatched = 0;

  // Pending bytes per requester: bit 8 is the last flag.
  logic [8:0] byte_q [NUM][$];
  int         gap_left [NUM];
  logic [7:0] exp_out [$];
  int         exp_own [$];
  int         served [$];
  int         deliv_cyc [$];
  int         model_last;
  int         sim_cnt;
  int         hold_cnt;

  task automatic drive_reqs();
    logic [8:0] b;
    for (int i = 0; i < NUM; i++) begin
      if (byte_q[i].size() > 0 && gap_left[i] == 0) begin
        b = byte_q[i][0];
        bus.req_valid[i]        = 1'b1;
        bus.req_data[i*8 +: 8]  = b[7:0];
        bus.req_last[i]         = b[8];
      end else begin
        bus.req_valid[i]        = 1'b0;
        bus.req_data[i*8 +: 8]  = 8'h00;
        bus.req_last[i]         = 1'b0;
      end
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NUM; i++) begin
      byte_q[i].delete();
      gap_left[i] = 0;
    end
  endtask

  task automatic load_pkt(input int r, input int len);
    logic l;
    for (int k = 0; k < len; k++) begin
      l = (k == len - 1);
      byte_q[r].push_back({l, 8'($urandom)});
    end
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    bus.tx_fifo_ready = 1'b1;
    for (int i = 0; i < NUM; i++) gap_left[i] = 0;
    drive_reqs();
    repeat (2) @(negedge aclk);
    aresetn    = 1'b1;
    model_last = NUM - 1;
  endtask

  // Packet-level model: whole packets are served round-robin after the previous owner.
  task automatic build_model();
    logic [8:0] cpy [NUM][$];
    logic [8:0] b;
    int         r;
    int         c;
    exp_out.delete();
    exp_own.delete();
    for (int i = 0; i < NUM; i++) cpy[i] = byte_q[i];
    forever begin
      r = -1;
      for (int k = 1; k <= NUM; k++) begin
        c = (model_last + k) % NUM;
        if (r < 0 && cpy[c].size() > 0) r = c;
      end
      if (r < 0) break;
      forever begin
        b = cpy[r].pop_front();
        exp_out.push_back(b[7:0]);
        if (b[8] || cpy[r].size() == 0) break;
      end
      exp_own.push_back(r);
      model_last = r;
    end
  endtask

  task automatic run_traffic(input int gap_pct, input int stall_pct, input int hold_from,
                             input int hold_len, input int max_cycles);
    logic       prev_acc, prev_hold, prev_last, done, acc_last;
    logic [7:0] prev_byte, prev_data, acc_byte, e;
    logic [8:0] b;
    int         cyc, acc_cnt;
    build_model();
    deliv_cyc.delete();
    served.delete();
    sim_cnt   = 0;
    hold_cnt  = 0;
    prev_acc  = 1'b0;
    prev_hold = 1'b0;
    prev_last = 1'b0;
    prev_byte = 8'h00;
    prev_data = 8'h00;
    acc_byte  = 8'h00;
    done      = 1'b0;
    cyc       = 0;
    while (!done && cyc < max_cycles) begin
      @(negedge aclk);
      if (cyc >= hold_from && cyc < hold_from + hold_len) bus.tx_fifo_ready = 1'b0;
      else bus.tx_fifo_ready = ($urandom_range(0, 99) >= stall_pct);
      drive_reqs();
      #1;
      if (prev_acc) begin
        compared++;
        if (bus.tx_fifo_valid !== 1'b1 || bus.tx_fifo_data !== prev_byte) begin
          mismatched++;
          $display("[TB] FAIL latency: got valid=%b data=%h expected valid=1 data=%h",
                   bus.tx_fifo_valid, bus.tx_fifo_data, prev_byte);
        end
      end
      if (prev_hold) begin
        compared++;
        if (bus.tx_fifo_valid !== 1'b1 || bus.tx_fifo_data !== prev_data) begin
          mismatched++;
          $display("[TB] FAIL hold_stable: got valid=%b data=%h expected valid=1 data=%h",
                   bus.tx_fifo_valid, bus.tx_fifo_data, prev_data);
        end
      end
      if (prev_last) begin
        compared++;
        if (busy !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL busy_after_last: got %b expected 0", busy);
        end
      end
      compared++;
      if (err_timeout !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL no_timeout: got %b expected 0", err_timeout);
      end
      if (bus.tx_fifo_valid && !bus.tx_fifo_ready) begin
        hold_cnt++;
        compared++;
        if (bus.req_ready !== '0) begin
          mismatched++;
          $display("[TB] FAIL ready_in_stall: got %b expected 0000", bus.req_ready);
        end
      end
      compared++;
      if ($countones(bus.req_ready) > 1) begin
        mismatched++;
        $display("[TB] FAIL ready_onehot: got %b expected at most one bit", bus.req_ready);
      end
      if (bus.tx_fifo_valid && bus.tx_fifo_ready) begin
        deliv_cyc.push_back(cyc);
        compared++;
        if (exp_out.size() == 0) begin
          mismatched++;
          $display("[TB] FAIL extra_byte: got %h expected none", bus.tx_fifo_data);
        end else begin
          e = exp_out.pop_front();
          if (bus.tx_fifo_data !== e) begin
            mismatched++;
            $display("[TB] FAIL out_byte: got %h expected %h", bus.tx_fifo_data, e);
          end
        end
      end
      acc_cnt  = 0;
      acc_last = 1'b0;
      for (int i = 0; i < NUM; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          acc_cnt++;
          b        = byte_q[i].pop_front();
          acc_byte = b[7:0];
          acc_last = b[8];
          compared++;
          if (exp_own.size() == 0 || exp_own[0] != i || grant_id !== 2'(i) || busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL owner: got req=%0d grant_id=%0d busy=%b expected req=%0d busy=1",
                     i, grant_id, busy, (exp_own.size() > 0) ? exp_own[0] : -1);
          end
          if (b[8]) begin
            served.push_back(i);
            if (exp_own.size() > 0) void'(exp_own.pop_front());
          end else begin
            gap_left[i] = ($urandom_range(0, 99) < gap_pct) ? int'($urandom_range(1, 4)) : 0;
          end
        end else if (!bus.req_valid[i] && gap_left[i] > 0) begin
          gap_left[i]--;
        end
      end
      if (acc_cnt > 0 && bus.tx_fifo_valid && bus.tx_fifo_ready) sim_cnt++;
      prev_hold = bus.tx_fifo_valid && !bus.tx_fifo_ready;
      prev_data = bus.tx_fifo_data;
      prev_acc  = (acc_cnt > 0);
      prev_byte = acc_byte;
      prev_last = (acc_cnt > 0) && acc_last;
      cyc++;
      done = (exp_out.size() == 0 && acc_cnt == 0);
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("[TB] FAIL run_timeout: got %0d bytes undelivered expected 0", exp_out.size());
    end
    bus.req_valid = '0;
  endtask

  task automatic test_reset();
    aresetn           = 1'b0;
    bus.req_valid     = '1;
    bus.req_last      = '1;
    bus.req_data      = $urandom;
    bus.tx_fifo_ready = 1'b1;
    @(negedge aclk);
    #1;
    compared += 6;
    if (grant_id !== 2'd0) begin mismatched++; $display("[TB] FAIL rst_grant: got %0d expected 0", grant_id); end
    if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    if (err_timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_err: got %b expected 0", err_timeout); end
    if (bus.tx_fifo_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rst_valid: got %b expected 0", bus.tx_fifo_valid); end
    if (bus.tx_fifo_data !== 8'h00) begin mismatched++; $display("[TB] FAIL rst_data: got %h expected 00", bus.tx_fifo_data); end
    if (bus.req_ready !== '0) begin mismatched++; $display("[TB] FAIL rst_ready: got %b expected 0000", bus.req_ready); end
    bus.req_valid = '0;
    bus.req_last  = '0;
    @(negedge aclk);
    aresetn    = 1'b1;
    model_last = NUM - 1;
    #1;
    compared++;
    if (bus.req_ready !== '0 || busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rst_release: got ready=%b busy=%b expected 0000/0", bus.req_ready, busy);
    end
  endtask

  task automatic test_single();
    clear_queues();
    byte_q[2].push_back({1'b0, 8'h11});
    byte_q[2].push_back({1'b0, 8'h22});
    byte_q[2].push_back({1'b1, 8'h33});
    run_traffic(0, 0, 1000, 0, 100);
    compared++;
    if (deliv_cyc.size() != 3) begin
      mismatched++;
      $display("[TB] FAIL single_count: got %0d expected 3", deliv_cyc.size());
    end else begin
      compared++;
      if (deliv_cyc[1] - deliv_cyc[0] != 1 || deliv_cyc[2] - deliv_cyc[1] != 1) begin
        mismatched++;
        $display("[TB] FAIL single_consecutive: got cycles %0d,%0d,%0d expected consecutive",
                 deliv_cyc[0], deliv_cyc[1], deliv_cyc[2]);
      end
    end
    compared++;
    if (grant_id !== 2'd2) begin
      mismatched++;
      $display("[TB] FAIL single_grant: got %0d expected 2", grant_id);
    end
  endtask

  task automatic test_contention();
    int exp_order [6] = '{0, 1, 3, 0, 1, 3};
    clear_queues();
    for (int round = 0; round < 2; round++) begin
      load_pkt(0, 2);
      load_pkt(1, 2);
      load_pkt(3, 2);
    end
    do_reset();
    run_traffic(0, 0, 1000, 0, 200);
    compared++;
    if (served.size() != 6) begin
      mismatched++;
      $display("[TB] FAIL contention_count: got %0d expected 6", served.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        compared++;
        if (served[k] != exp_order[k]) begin
          mismatched++;
          $display("[TB] FAIL contention_order[%0d]: got %0d expected %0d", k, served[k], exp_order[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    clear_queues();
    load_pkt(0, 4);
    run_traffic(0, 0, 3, 10, 200);
    compared++;
    if (hold_cnt != 10) begin
      mismatched++;
      $display("[TB] FAIL backpressure_hold: got %0d held cycles expected 10", hold_cnt);
    end
  endtask

  task automatic test_drain_accept();
    clear_queues();
    load_pkt(3, 3);
    run_traffic(0, 0, 2, 3, 200);
    compared++;
    if (sim_cnt != 2) begin
      mismatched++;
      $display("[TB] FAIL drain_accept: got %0d overlapped cycles expected 2", sim_cnt);
    end
  endtask

  task automatic test_random();
    for (int iter = 0; iter < 3; iter++) begin
      clear_queues();
      for (int i = 0; i < NUM; i++) begin
        for (int p = 0; p < int'($urandom_range(2, 3)); p++) load_pkt(i, int'($urandom_range(1, 4)));
      end
      run_traffic(30, 30, 1000, 0, 3000);
    end
  endtask

  task automatic test_timeout();
    int   acc_at, pulse_at, g2_at, pulses;
    logic saw_a5, drop1, drop2;
    clear_queues();
    do_reset();
    acc_at = -1; pulse_at = -1; g2_at = -1; pulses = 0;
    saw_a5 = 1'b0; drop1 = 1'b0; drop2 = 1'b0;
    for (int s = 0; s < 60; s++) begin
      @(negedge aclk);
      bus.tx_fifo_ready      = 1'b1;
      bus.req_valid          = '0;
      bus.req_last           = '0;
      bus.req_data           = '0;
      bus.req_valid[1]       = !drop1;
      bus.req_data[15:8]     = 8'hA5;
      bus.req_valid[2]       = !drop2;
      bus.req_data[23:16]    = 8'h5A;
      bus.req_last[2]        = 1'b1;
      #1;
      if (bus.tx_fifo_valid && bus.tx_fifo_data == 8'hA5) saw_a5 = 1'b1;
      if (err_timeout) begin
        pulses++;
        pulse_at = s;
        compared++;
        if (busy !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL timeout_busy: got %b expected 0", busy);
        end
      end
      if (bus.req_valid[1] && bus.req_ready[1]) begin
        acc_at = s;
        drop1  = 1'b1;
      end
      if (bus.req_valid[2] && bus.req_ready[2]) begin
        g2_at = s;
        drop2 = 1'b1;
        compared++;
        if (grant_id !== 2'd2) begin
          mismatched++;
          $display("[TB] FAIL timeout_regrant: got %0d expected 2", grant_id);
        end
      end
    end
    bus.req_valid = '0;
    model_last    = 2;
    compared += 4;
    if (acc_at < 0 || !saw_a5) begin
      mismatched++;
      $display("[TB] FAIL timeout_byte: got accept_at=%0d delivered=%b expected accepted and delivered", acc_at, saw_a5);
    end
    if (pulses != 1) begin
      mismatched++;
      $display("[TB] FAIL timeout_pulses: got %0d expected 1", pulses);
    end
    if (pulse_at - acc_at != TMO + 1) begin
      mismatched++;
      $display("[TB] FAIL timeout_delay: got %0d expected %0d", pulse_at - acc_at, TMO + 1);
    end
    if (g2_at != pulse_at + 1) begin
      mismatched++;
      $display("[TB] FAIL timeout_next: got accept_at=%0d expected %0d", g2_at, pulse_at + 1);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_queues();
    do_reset();
    load_pkt(2, 4);
    n = 0;
    for (int s = 0; s < 20 && n < 2; s++) begin
      @(negedge aclk);
      bus.tx_fifo_ready = 1'b1;
      drive_reqs();
      #1;
      if (bus.req_valid[2] && bus.req_ready[2]) begin
        void'(byte_q[2].pop_front());
        n++;
      end
    end
    compared++;
    if (n != 2) begin
      mismatched++;
      $display("[TB] FAIL midrst_setup: got %0d accepts expected 2", n);
    end
    aresetn = 1'b0;
    #1;
    compared++;
    if (bus.tx_fifo_valid !== 1'b0 || bus.tx_fifo_data !== 8'h00 || grant_id !== 2'd0 ||
        busy !== 1'b0 || err_timeout !== 1'b0 || bus.req_ready !== '0) begin
      mismatched++;
      $display("[TB] FAIL midrst_outputs: got valid=%b data=%h grant=%0d busy=%b err=%b ready=%b expected 0/00/0/0/0/0000",
               bus.tx_fifo_valid, bus.tx_fifo_data, grant_id, busy, err_timeout, bus.req_ready);
    end
    clear_queues();
    load_pkt(2, 3);
    load_pkt(0, 2);
    drive_reqs();
    @(negedge aclk);
    aresetn    = 1'b1;
    model_last = NUM - 1;
    #1;
    compared++;
    if (bus.req_ready !== '0) begin
      mismatched++;
      $display("[TB] FAIL midrst_ready: got %b expected 0000", bus.req_ready);
    end
    run_traffic(0, 0, 1000, 0, 200);
    compared++;
    if (served.size() < 1 || served[0] != 0) begin
      mismatched++;
      $display("[TB] FAIL midrst_first: got %0d expected 0", (served.size() > 0) ? served[0] : -1);
    end
  endtask

  initial begin
    bus.req_data      = '0;
    bus.req_valid     = '0;
    bus.req_last      = '0;
    bus.tx_fifo_ready = 1'b1;
    model_last        = NUM - 1;
    for (int i = 0; i < NUM; i++) gap_left[i] = 0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_drain_accept();
    test_random();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
